// File: rtl/afu_job_ctrl_if.sv
// Host read/write ports and afu_user FIFO ports of the job sequencer.
// master = sequencer side, slave = host memory / afu_user side.
interface afu_job_ctrl_if #(
   parameter int FIFO_DEPTH_BITS = 3
);
   logic                     rd_req_valid;
   logic [31:0]              rd_req_idx;
   logic                     rd_req_ready;
   logic                     rd_rsp_valid;
   logic [511:0]             rd_rsp_data;
   logic [511:0]             input_fifo_din;
   logic                     input_fifo_we;
   logic [FIFO_DEPTH_BITS:0] input_fifo_count;
   logic [511:0]             output_fifo_dout;
   logic                     output_fifo_re;
   logic                     output_fifo_empty;
   logic                     wr_req_valid;
   logic [31:0]              wr_req_idx;
   logic [511:0]             wr_req_data;
   logic                     wr_req_ready;

   modport master (
      output rd_req_valid, rd_req_idx, input_fifo_din, input_fifo_we,
             output_fifo_re, wr_req_valid, wr_req_idx, wr_req_data,
      input  rd_req_ready, rd_rsp_valid, rd_rsp_data, input_fifo_count,
             output_fifo_dout, output_fifo_empty, wr_req_ready
   );

   modport slave (
      input  rd_req_valid, rd_req_idx, input_fifo_din, input_fifo_we,
             output_fifo_re, wr_req_valid, wr_req_idx, wr_req_data,
      output rd_req_ready, rd_rsp_valid, rd_rsp_data, input_fifo_count,
             output_fifo_dout, output_fifo_empty, wr_req_ready
   );
endinterface

// File: rtl/afu_job_ctrl.sv
// Job sequencer for the matrix-transpose AFU: credit-limited line reads into
// afu_user, output FIFO drained into indexed writes. AFU_JOB_CTRL_PERF_EN builds perf counters.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads, collecting responses, draining output
// FLUSH | all responses in, draining remaining output lines
// DONE  | one-cycle completion pulse
module afu_job_ctrl #(
   parameter int FIFO_DEPTH_BITS = 3,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [31:0]   ctx_length,
   output logic          busy,
   output logic          done,
   output logic [31:0]   perf_cycles,
   output logic [31:0]   perf_rd_stall,
   afu_job_ctrl_if.master bus
);
   localparam logic [31:0] FIFO_DEPTH = 32'(1 << FIFO_DEPTH_BITS);
   localparam logic [31:0] MAX_OS     = 32'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t       state, state_nxt;
   logic [31:0]  len_q, rd_cnt, rsp_cnt, wr_cnt, outstanding;
   logic         pending_re;
   logic [1:0]   buffered;
   logic [511:0] buf0, buf1;
   logic         start_acc, active, rd_hs, rsp_acc, wr_hs;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nxt = (ctx_length == 32'd0) ? DONE : RUN;
            end
         end
         RUN:     if (rsp_cnt == len_q) state_nxt = FLUSH;
         FLUSH:   if (wr_cnt == len_q)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign active = (state == RUN) || (state == FLUSH);

   // Credits: lines in flight plus lines already queued must fit the input FIFO.
   assign bus.rd_req_valid = (state == RUN) && (rd_cnt < len_q) && (outstanding < MAX_OS) &&
                             ((32'(bus.input_fifo_count) + outstanding) < FIFO_DEPTH);
   assign bus.rd_req_idx   = rd_cnt;
   assign rd_hs            = bus.rd_req_valid && bus.rd_req_ready;

   assign rsp_acc            = bus.rd_rsp_valid && busy;
   assign bus.input_fifo_we  = rsp_acc;
   assign bus.input_fifo_din = bus.rd_rsp_data;

   assign bus.output_fifo_re = !bus.output_fifo_empty && active &&
                               (({1'b0, buffered} + {2'b00, pending_re}) < 3'd2);

   // Line read last cycle is presented straight from the FIFO when nothing is queued ahead.
   assign bus.wr_req_valid = (buffered != 2'd0) || pending_re;
   assign bus.wr_req_data  = ((buffered == 2'd0) && pending_re) ? bus.output_fifo_dout : buf0;
   assign bus.wr_req_idx   = wr_cnt;
   assign wr_hs            = bus.wr_req_valid && bus.wr_req_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q       <= '0;
         rd_cnt      <= '0;
         rsp_cnt     <= '0;
         wr_cnt      <= '0;
         outstanding <= '0;
         pending_re  <= 1'b0;
         buffered    <= '0;
         buf0        <= '0;
         buf1        <= '0;
      end else if (start_acc) begin
         len_q       <= ctx_length;
         rd_cnt      <= '0;
         rsp_cnt     <= '0;
         wr_cnt      <= '0;
         outstanding <= '0;
         pending_re  <= 1'b0;
         buffered    <= '0;
      end else begin
         if (rd_hs)   rd_cnt  <= rd_cnt + 32'd1;
         if (rsp_acc) rsp_cnt <= rsp_cnt + 32'd1;
         if (wr_hs)   wr_cnt  <= wr_cnt + 32'd1;
         case ({rd_hs, rsp_acc})
            2'b10:   outstanding <= outstanding + 32'd1;
            2'b01:   outstanding <= outstanding - 32'd1;
            default: outstanding <= outstanding;
         endcase
         pending_re <= bus.output_fifo_re;
         if (wr_hs) buf0 <= buf1;
         if (pending_re) begin
            if (wr_hs) begin
               if (buffered == 2'd1)      buf0 <= bus.output_fifo_dout;
               else if (buffered == 2'd2) buf1 <= bus.output_fifo_dout;
            end else begin
               if (buffered == 2'd0) buf0 <= bus.output_fifo_dout;
               else                  buf1 <= bus.output_fifo_dout;
            end
         end
         buffered <= buffered + {1'b0, pending_re} - {1'b0, wr_hs};
      end
   end

`ifdef AFU_JOB_CTRL_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_cycles   <= '0;
         perf_rd_stall <= '0;
      end else if (start_acc) begin
         perf_cycles   <= '0;
         perf_rd_stall <= '0;
      end else begin
         if (busy && (perf_cycles != 32'hFFFF_FFFF))
            perf_cycles <= perf_cycles + 32'd1;
         if (bus.rd_req_valid && !bus.rd_req_ready && (perf_rd_stall != 32'hFFFF_FFFF))
            perf_rd_stall <= perf_rd_stall + 32'd1;
      end
   end
`else
   assign perf_cycles   = '0;
   assign perf_rd_stall = '0;
`endif
endmodule

// File: tb/tb_afu_job_ctrl.sv
// Scoreboard bench for afu_job_ctrl: host/afu_user loopback model, expectations queued at
// job start and popped by a monitor on every read/write handshake.
module tb_afu_job_ctrl;
   localparam int FDB = 3;
   localparam int MOS = 4;
   localparam int CW  = FDB + 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] ctx_length = '0;
   logic        busy, done;
   logic [31:0] perf_cycles, perf_rd_stall;

   afu_job_ctrl_if #(.FIFO_DEPTH_BITS(FDB)) bus ();

   afu_job_ctrl #(.FIFO_DEPTH_BITS(FDB), .MAX_OUTSTANDING(MOS)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .ctx_length   (ctx_length),
      .busy         (busy),
      .done         (done),
      .perf_cycles  (perf_cycles),
      .perf_rd_stall(perf_rd_stall),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [511:0] line_data(input int job, input logic [31:0] idx);
      logic [31:0] w;
      w = idx ^ (32'(job) << 24) ^ 32'h0013_5700;
      return {16{w}};
   endfunction

   // ---------------- host / afu_user environment ----------------
   typedef struct {int due; logic [31:0] idx;} rsp_t;
   typedef struct {logic [31:0] idx; logic [511:0] data;} wr_t;

   rsp_t         rsp_q[$];
   logic [511:0] in_q[$];
   logic [511:0] out_q[$];
   logic [511:0] dout_next = '0;
   int rsp_lat = 1, drain_div = 1, wr_rand = 0, rd_low = 0, cyc = 0, job_id = 0;

   initial begin
      bus.rd_req_ready      = 1'b1;
      bus.rd_rsp_valid      = 1'b0;
      bus.rd_rsp_data       = '0;
      bus.input_fifo_count  = '0;
      bus.output_fifo_dout  = '0;
      bus.output_fifo_empty = 1'b1;
      bus.wr_req_ready      = 1'b1;
      forever begin
         @(negedge clk);
         bus.rd_rsp_valid = 1'b0;
         bus.rd_rsp_data  = '0;
         if (rsp_q.size() > 0) begin
            if (rsp_q[0].due <= cyc) begin
               bus.rd_rsp_valid = 1'b1;
               bus.rd_rsp_data  = line_data(job_id, rsp_q[0].idx);
            end
         end
         bus.input_fifo_count  = CW'(in_q.size());
         bus.output_fifo_empty = (out_q.size() == 0);
         bus.output_fifo_dout  = dout_next;
         bus.wr_req_ready      = (wr_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.rd_req_ready      = (rd_low == 0);
         #1;
         if (reset_n) begin
            if (bus.rd_req_valid && bus.rd_req_ready) rsp_q.push_back('{cyc + rsp_lat, bus.rd_req_idx});
            if (bus.rd_req_valid && !bus.rd_req_ready && rd_low > 0) rd_low--;
            if (bus.rd_rsp_valid) void'(rsp_q.pop_front());
            if (in_q.size() > 0 && (cyc % drain_div) == 0) out_q.push_back(in_q.pop_front());
            if (bus.input_fifo_we) in_q.push_back(bus.input_fifo_din);
            if (bus.output_fifo_re) begin
               if (out_q.size() == 0) fail_now("output_fifo_underflow");
               else dout_next = out_q.pop_front();
            end
         end
         cyc++;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [31:0]  exp_rd_q[$];
   wr_t          exp_wr_q[$];
   int           os_model = 0, rd_hs_n = 0, wr_hs_n = 0, done_n = 0, mcyc = 0;
   int           last_wr_m = 0, busy_cnt = 0, cur_len = 0;
   logic         prev_stall = 1'b0, prev_done = 1'b0, prev_busy = 1'b0;
   logic [31:0]  prev_idx = '0;
   logic [511:0] prev_data = '0;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         mcyc++;
         if (!reset_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            prev_busy  = 1'b0;
            os_model   = 0;
            continue;
         end
         if (busy) busy_cnt++;
         if (bus.rd_req_valid && bus.rd_req_ready) begin
            rd_hs_n++;
            os_model++;
            if (exp_rd_q.size() == 0) fail_now("rd_extra_request");
            else chk("rd_idx", bus.rd_req_idx, exp_rd_q.pop_front());
            chk("outstanding_le_max", os_model <= MOS, 1);
            chk("credit_le_depth", (int'(bus.input_fifo_count) + os_model) <= (1 << FDB), 1);
         end
         if (bus.rd_rsp_valid) begin
            os_model--;
            chk("fifo_we", bus.input_fifo_we, 1);
            chk("fifo_din", bus.input_fifo_din, bus.rd_rsp_data);
         end
         if (bus.wr_req_valid) begin
            if (prev_stall) begin
               chk("wr_stall_idx", bus.wr_req_idx, prev_idx);
               chk("wr_stall_data", bus.wr_req_data, prev_data);
            end
            if (bus.wr_req_ready) begin
               wr_hs_n++;
               last_wr_m = mcyc;
               if (exp_wr_q.size() == 0) fail_now("wr_extra_line");
               else begin
                  wr_t e;
                  e = exp_wr_q.pop_front();
                  chk("wr_idx", bus.wr_req_idx, e.idx);
                  chk("wr_data", bus.wr_req_data, e.data);
               end
            end
         end
         prev_stall = bus.wr_req_valid && !bus.wr_req_ready;
         prev_idx   = bus.wr_req_idx;
         prev_data  = bus.wr_req_data;
         if (done) begin
            done_n++;
            chk("done_single_cycle", prev_done, 0);
            chk("no_lost_lines", exp_wr_q.size(), 0);
            if (cur_len != 0) chk("done_after_last_wr", mcyc - last_wr_m, 2);
         end
         if (prev_busy && !busy && cur_len != 0) chk("busy_fall_after_last_wr", mcyc - last_wr_m, 3);
         prev_done = done;
         prev_busy = busy;
      end
   end

   // ---------------- stimulus ----------------
   task automatic queue_job(input int len);
      job_id++;
      cur_len = len;
      for (int i = 0; i < len; i++) begin
         exp_rd_q.push_back(32'(i));
         exp_wr_q.push_back('{32'(i), line_data(job_id, 32'(i))});
      end
   endtask

   task automatic pulse_start(input int len);
      @(negedge clk); #3;
      ctx_length = 32'(len);
      start = 1'b1;
      @(negedge clk); #3;
      start = 1'b0;
      if (len > 0) begin
         chk("first_rd_valid", bus.rd_req_valid, 1);
         chk("first_rd_idx", bus.rd_req_idx, 0);
      end else begin
         chk("zero_len_no_rd", bus.rd_req_valid, 0);
      end
   endtask

   task automatic run_job(input int len);
      int d0, r0, w0, n;
      d0 = done_n; r0 = rd_hs_n; w0 = wr_hs_n; n = 0;
      queue_job(len);
      pulse_start(len);
      while (done_n == d0 && n < 2000) begin
         @(negedge clk); #3;
         n++;
      end
      if (done_n == d0) fail_now("done_timeout");
      repeat (4) @(negedge clk);
      #3;
      chk("done_count", done_n - d0, 1);
      chk("busy_idle", busy, 0);
      chk("rd_count", rd_hs_n - r0, len);
      chk("wr_count", wr_hs_n - w0, len);
   endtask

   initial begin
      int d0, w0, n, b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_valid", bus.rd_req_valid, 0);
      chk("rst_fifo_we", bus.input_fifo_we, 0);
      chk("rst_fifo_re", bus.output_fifo_re, 0);
      chk("rst_wr_valid", bus.wr_req_valid, 0);
      chk("rst_rd_idx", bus.rd_req_idx, 0);
      chk("rst_wr_idx", bus.wr_req_idx, 0);
      chk("rst_wr_data", bus.wr_req_data, 0);
      chk("rst_fifo_din", bus.input_fifo_din, 0);
      chk("rst_perf_cycles", perf_cycles, 0);
      chk("rst_perf_stall", perf_rd_stall, 0);
      reset_n = 1'b1;

      run_job(8);
      run_job(0);

      rsp_lat = 20; drain_div = 3;
      run_job(16);
      rsp_lat = 1; drain_div = 1;

      wr_rand = 1;
      run_job(16);
      wr_rand = 0;

      // reset in the middle of a 12-line job after 5 written lines
      d0 = done_n; w0 = wr_hs_n; n = 0;
      queue_job(12);
      pulse_start(12);
      while ((wr_hs_n - w0) < 5 && n < 2000) begin
         @(negedge clk); #3;
         n++;
      end
      if ((wr_hs_n - w0) < 5) fail_now("mid_job_wr_timeout");
      reset_n = 1'b0;
      exp_rd_q.delete(); exp_wr_q.delete();
      rsp_q.delete(); in_q.delete(); out_q.delete();
      dout_next = '0;
      repeat (2) @(negedge clk);
      #3;
      chk("midrst_busy", busy, 0);
      chk("midrst_rd_valid", bus.rd_req_valid, 0);
      chk("midrst_wr_valid", bus.wr_req_valid, 0);
      chk("midrst_no_done", done_n - d0, 0);
      reset_n = 1'b1;
      run_job(3);

      b0 = busy_cnt;
      rd_low = 10;
      run_job(4);
`ifdef AFU_JOB_CTRL_PERF_EN
      chk("perf_rd_stall", perf_rd_stall, 10);
      chk("perf_cycles", perf_cycles, busy_cnt - b0);
`else
      chk("perf_rd_stall_off", perf_rd_stall, 0);
      chk("perf_cycles_off", perf_cycles, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule
